// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EXE->MEM register with valid/ready, 2-entry skid (MAIN drives outputs), sync flush, async active-low rst; count = occupancy
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] ST_val_in,
  input  logic [DEST_W-1:0] Dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic              MEM_W_EN,
  output logic [DATA_W-1:0] ALU_result,
  output logic [DATA_W-1:0] ST_val,
  output logic [DEST_W-1:0] Dest,
  output logic [1:0]        count
);
  localparam int E = 3 + 2 * DATA_W + DEST_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_d;
  logic [E-1:0] main_q, skid_q, main_d, skid_d, din;
  logic in_fire, out_fire;
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign count = state;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign din = {WB_en_in, MEM_R_EN_in, MEM_W_EN_in, ALU_result_in, ST_val_in, Dest_in};
  assign {WB_en, MEM_R_EN, MEM_W_EN, ALU_result, ST_val, Dest} = main_q;
  always_comb begin
    state_d = (state == EMPTY) ? (in_fire ? ONE : EMPTY) :
              (state == ONE) ? ((in_fire && !out_fire) ? TWO : (out_fire && !in_fire) ? EMPTY : ONE) :
              (out_fire ? ONE : TWO);
    main_d = (state == TWO) ? (out_fire ? skid_q : main_q) :
             (in_fire && (state == EMPTY || out_fire)) ? din :
             out_fire ? '0 : main_q;
    skid_d = (state == TWO) ? (out_fire ? '0 : skid_q) :
             (state == ONE && in_fire && !out_fire) ? din : skid_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb_exe_mem_skid_reg: directed checks of exe_mem_skid_reg (default and 64/5 widths)
module tb_exe_mem_skid_reg;
  logic clk = 0, rst = 0, flush = 0;
  logic in_valid = 0, out_ready = 0, wb_i = 0, mr_i = 0, mw_i = 0;
  logic [31:0] alu_i = 0, st_i = 0;
  logic [3:0] dest_i = 0;
  logic in_ready, out_valid, wb, mr, mw;
  logic [31:0] alu, st;
  logic [3:0] dest;
  logic [1:0] count;
  logic w_in_valid = 0, w_out_ready = 1, w_mw_i = 0;
  logic [63:0] w_alu_i = 0, w_st_i = 0;
  logic [4:0] w_dest_i = 0;
  logic w_in_ready, w_out_valid, w_wb, w_mr, w_mw;
  logic [63:0] w_alu, w_st;
  logic [4:0] w_dest;
  logic [1:0] w_count;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  exe_mem_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .WB_en_in(wb_i), .MEM_R_EN_in(mr_i), .MEM_W_EN_in(mw_i), .ALU_result_in(alu_i),
    .ST_val_in(st_i), .Dest_in(dest_i), .out_valid(out_valid), .out_ready(out_ready),
    .WB_en(wb), .MEM_R_EN(mr), .MEM_W_EN(mw), .ALU_result(alu), .ST_val(st),
    .Dest(dest), .count(count)
  );
  exe_mem_skid_reg #(.DATA_W(64), .DEST_W(5)) dut_w (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .WB_en_in(1'b0), .MEM_R_EN_in(1'b0), .MEM_W_EN_in(w_mw_i), .ALU_result_in(w_alu_i),
    .ST_val_in(w_st_i), .Dest_in(w_dest_i), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .WB_en(w_wb), .MEM_R_EN(w_mr), .MEM_W_EN(w_mw), .ALU_result(w_alu), .ST_val(w_st),
    .Dest(w_dest), .count(w_count)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic put(input logic v, input logic w, input logic r, input logic m,
                     input logic [31:0] a, input logic [31:0] s, input logic [3:0] d);
    in_valid = v; wb_i = w; mr_i = r; mw_i = m; alu_i = a; st_i = s; dest_i = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    step();
    rst = 1;
    put(1, 1, 0, 0, 32'hA1, 32'h5, 4'd1);
    step();
    chk("t1_fill1_count", count, 1);
    put(1, 1, 1, 1, 32'hA2, 32'h6, 4'd2);
    step();
    chk("t1_fill2_count", count, 2);
    chk("t1_fill2_in_ready", in_ready, 0);
    chk("t1_fill2_alu", alu, 32'hA1);
    put(0, 0, 0, 0, 0, 0, 0);
    #3 rst = 0;
    #1;
    chk("t1_rst_out_valid", out_valid, 0);
    chk("t1_rst_alu", alu, 0);
    chk("t1_rst_wb", wb, 0);
    chk("t1_rst_dest", dest, 0);
    chk("t1_rst_count", count, 0);
    chk("t1_rst_in_ready", in_ready, 1);
    step();
    rst = 1;
    out_ready = 1;
    put(1, 1, 0, 0, 32'h11, 32'hC1, 4'd3);
    step();
    chk("t2_out11", alu, 32'h11);
    chk("t2_st11", st, 32'hC1);
    chk("t2_count1", count, 1);
    put(1, 0, 1, 0, 32'h22, 32'hC2, 4'd4);
    step();
    chk("t2_out22", alu, 32'h22);
    chk("t2_mr22", mr, 1);
    chk("t2_count2", count, 1);
    put(1, 0, 0, 1, 32'h33, 32'hC3, 4'd5);
    step();
    chk("t2_out33", alu, 32'h33);
    chk("t2_count3", count, 1);
    chk("t2_dest33", dest, 5);
    put(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t2_drain_valid", out_valid, 0);
    chk("t2_drain_alu", alu, 0);
    chk("t2_drain_mw", mw, 0);
    out_ready = 0;
    put(1, 1, 0, 0, 32'h100, 32'h1, 4'd2);
    step();
    chk("t3_A_count", count, 1);
    put(1, 1, 0, 0, 32'h200, 32'h2, 4'd3);
    step();
    chk("t3_AB_count", count, 2);
    chk("t3_AB_in_ready", in_ready, 0);
    chk("t3_AB_head", alu, 32'h100);
    put(1, 1, 0, 0, 32'h300, 32'h3, 4'd4);
    step();
    chk("t3_C_held_count", count, 2);
    chk("t3_C_held_head", alu, 32'h100);
    out_ready = 1;
    step();
    chk("t3_B_head", alu, 32'h200);
    chk("t3_B_count", count, 1);
    step();
    chk("t3_C_head", alu, 32'h300);
    chk("t3_C_valid", out_valid, 1);
    chk("t3_C_dest", dest, 4);
    put(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t3_empty", out_valid, 0);
    out_ready = 0;
    put(1, 1, 1, 1, 32'h400, 32'h4, 4'd6);
    step();
    put(1, 1, 1, 1, 32'h500, 32'h5, 4'd7);
    step();
    chk("t4_full", count, 2);
    put(1, 1, 1, 1, 32'h600, 32'h6, 4'd8);
    flush = 1;
    step();
    flush = 0;
    chk("t4_flush_valid", out_valid, 0);
    chk("t4_flush_wb", wb, 0);
    chk("t4_flush_mr", mr, 0);
    chk("t4_flush_mw", mw, 0);
    chk("t4_flush_count", count, 0);
    chk("t4_flush_alu", alu, 0);
    put(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t4_dropped_count", count, 0);
    chk("t4_dropped_valid", out_valid, 0);
    put(1, 1, 0, 0, 32'h1234, 32'h9, 4'd3);
    step();
    chk("t5_pre_count", count, 1);
    out_ready = 1;
    put(1, 0, 1, 0, 32'hABCD, 32'h8, 4'd7);
    step();
    chk("t5_count", count, 1);
    chk("t5_alu", alu, 32'hABCD);
    chk("t5_dest", dest, 7);
    put(0, 0, 0, 0, 0, 0, 0);
    step();
    chk("t5_drain", count, 0);
    w_in_valid = 1; w_mw_i = 1; w_alu_i = 64'hFFFF_FFFF_0000_0001;
    w_st_i = 64'h8000_0000_0000_0003; w_dest_i = 5'd31;
    step();
    chk("t6_valid", w_out_valid, 1);
    chk("t6_alu", w_alu, 64'hFFFF_FFFF_0000_0001);
    chk("t6_st", w_st, 64'h8000_0000_0000_0003);
    chk("t6_dest", w_dest, 31);
    chk("t6_mw", w_mw, 1);
    chk("t6_wb", w_wb, 0);
    w_in_valid = 0; w_mw_i = 0;
    step();
    chk("t6_drain_valid", w_out_valid, 0);
    chk("t6_drain_mw", w_mw, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
